rng_arbiter: RTL and testbench
==============================

# rng_arbiter

Sequencer and round-robin arbiter sharing one 64-bit pseudo-random generator between NREQ consumers, such as the key-generation and per-message ephemeral-key units. After reset it seeds the generator once. It then serves requests one at a time, optionally rejection-samples each draw into the range [1, bound-1], and returns the value over a valid/ready handshake.

## Interface
- NREQ, 2, number of requesters (2..8)
- WIDTH, 64, delivered sample width; low WIDTH bits of generator word (1..64)
- MAX_RETRY, 15, rejected draws allowed before error return
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- seed  in  64  seed value, sampled in the SEED cycle
- gen_load  out  1  one-cycle pulse loading gen_seed into the generator
- gen_seed  out  64  registered seed
- gen_req  out  1  high while a sample is awaited
- gen_valid  in  1  generator sample strobe
- gen_data  in  64  generator sample
- req  in  NREQ  per-requester request; hold high until the handshake completes
- bound  in  NREQ*WIDTH  per-requester exclusive upper bound; slice i = bound[i*WIDTH +: WIDTH]
- out_valid  out  NREQ  one-hot; result valid for that requester
- out_ready  in  NREQ  per-requester accept
- rnd  out  WIDTH  result
- err  out  1  result invalid (retry exhaustion or bound < 2)
- busy  out  1  high in every state except IDLE

## Operation
- States: SEED, IDLE, WAIT, CHECK, DELIVER.
- SEED: entered from reset. gen_load=1 and gen_seed<=seed for one cycle, then IDLE.
- IDLE: if any req bit is set, grant g is the first set bit searching upward, circularly, from ptr+1.
  - Clear retry count.
  - If bound[g] < 2 (REJECT build only), go to DELIVER with rnd=0, err=1.
  - Otherwise go to WAIT.
- WAIT: gen_req=1. On gen_valid, sample<=gen_data[WIDTH-1:0], go to CHECK.
- CHECK: value is rejected if sample==0 or sample>=bound[g] (unsigned).
  - Rejected, retry<MAX_RETRY: retry+1, back to WAIT.
  - Rejected, retry==MAX_RETRY: DELIVER with rnd=0, err=1.
  - Accepted: DELIVER with rnd=sample, err=0.
- DELIVER: out_valid[g]=1; rnd and err held stable. When out_ready[g]=1, set ptr<=g, clear out_valid, go to IDLE.
- ptr resets to NREQ-1, so requester 0 has first priority after reset.
- The retry counter is wide enough for MAX_RETRY, with no wrap.
- Ignored inputs:
  - gen_valid outside WAIT.
  - out_ready bits other than out_ready[g].
  - req deasserted after grant; the transaction completes and out_valid waits for out_ready.
- Reset in any state: return to SEED on the next edge. Any in-flight draw is discarded and no out_valid is produced for it.

## Timing
- Reset values: gen_load=0, gen_seed=0, gen_req=0, out_valid=0, rnd=0, err=0, busy=1 (state SEED). Internal: ptr=NREQ-1, retry=0.
- First rst-low cycle: gen_load=1. IDLE is reached the cycle after.
- req seen in IDLE at edge N: gen_req high from N+1.
- gen_valid at edge M in WAIT:
  - CHECK during M+1.
  - Accepted: out_valid high from M+2.
  - Rejected: gen_req high again from M+2.
- Handshake: the transfer occurs on the edge where out_valid[g] and out_ready[g] are both high. out_valid drops the next cycle, and the earliest next grant is the cycle after that.
- The grant decision uses only registered state plus the current req. No combinational path from out_ready to out_valid.
- gen_req may be high continuously across consecutive retries.

## Configuration
- RNG_ARB_REJECT_EN defined:
  - Rejection sampling, bound<2 check, and retry counter are present.
  - err can be 1.
- RNG_ARB_REJECT_EN undefined:
  - CHECK always accepts, so rnd=gen_data[WIDTH-1:0], including 0.
  - bound is ignored and err is tied 0.
  - Latency is unchanged.

## Test plan
- Reset, then seed=64'h1234_5678_9ABC_DEF0 → gen_load pulses exactly once in the first rst-low cycle with gen_seed equal to seed. All other outputs match their reset values.
- REJECT build, WIDTH=64. req=01, bound[0]=100, gen_data sequence 0, 150, 42 → exactly three gen_req/gen_valid draws, then out_valid=01, rnd=42, err=0.
- REJECT build, MAX_RETRY=3, bound=5, gen_data always 9 → 4 draws, then out_valid asserted with rnd=0, err=1.
- req=11 held continuously, out_ready=11, six transactions → grants alternate 0,1,0,1,0,1, with requester 0 first after reset.
- out_ready[g] held low for 10 cycles in DELIVER → out_valid, rnd, and err stay stable. rst asserted in WAIT → SEED next cycle, out_valid=0, and the next grant goes to requester 0.
- Non-REJECT build, gen_data=0 → rnd=0, err=0 after a single draw.

Source files
------------

// File: rtl/rng_arbiter.sv
// rng_arbiter: seeds a shared 64-bit PRNG once, then round-robin serves requesters.
// Define RNG_ARB_REJECT_EN to add rejection sampling into [1, bound-1] with retry limit.
module rng_arbiter #(
  parameter int NREQ      = 2,
  parameter int WIDTH     = 64,
  parameter int MAX_RETRY = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [63:0]           seed,
  output logic                  gen_load,
  output logic [63:0]           gen_seed,
  output logic                  gen_req,
  input  logic                  gen_valid,
  input  logic [63:0]           gen_data,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] bound,
  output logic [NREQ-1:0]       out_valid,
  input  logic [NREQ-1:0]       out_ready,
  output logic [WIDTH-1:0]      rnd,
  output logic                  err,
  output logic                  busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    S_SEED,
    S_IDLE,
    S_WAIT,
    S_CHECK,
    S_DELIVER
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    g_q, g_d;
  logic [WIDTH-1:0] sample_q, sample_d;
  logic [WIDTH-1:0] rnd_d;
  logic             err_d;
  logic [63:0]      seed_q;
  logic [PW-1:0]    grant;
  logic             any_req;
  logic [PW-1:0]    idx;
  logic             unused_gen;

  assign unused_gen = ^gen_data;

`ifdef RNG_ARB_REJECT_EN
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  logic [RW-1:0]    retry_q, retry_d;
  logic [WIDTH-1:0] bnd [NREQ];

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      bnd[i] = bound[i*WIDTH +: WIDTH];
    end
  end
`else
  logic unused_bound;

  assign unused_bound = ^bound;
`endif

  // circular search upward from ptr+1
  always_comb begin
    grant   = ptr_q;
    any_req = 1'b0;
    idx     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = PW'((int'(ptr_q) + k) % NREQ);
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        grant   = idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    g_d      = g_q;
    sample_d = sample_q;
    rnd_d    = rnd;
    err_d    = err;
`ifdef RNG_ARB_REJECT_EN
    retry_d  = retry_q;
`endif
    gen_load = 1'b0;
    gen_req  = 1'b0;
    unique case (state_q)
      S_SEED: begin
        gen_load = ~rst;
        state_d  = S_IDLE;
      end
      S_IDLE: begin
        if (any_req) begin
          g_d = grant;
`ifdef RNG_ARB_REJECT_EN
          retry_d = '0;
          if ((bnd[grant] >> 1) == '0) begin
            rnd_d   = '0;
            err_d   = 1'b1;
            state_d = S_DELIVER;
          end else begin
            state_d = S_WAIT;
          end
`else
          state_d = S_WAIT;
`endif
        end
      end
      S_WAIT: begin
        gen_req = 1'b1;
        if (gen_valid) begin
          sample_d = gen_data[WIDTH-1:0];
          state_d  = S_CHECK;
        end
      end
      S_CHECK: begin
`ifdef RNG_ARB_REJECT_EN
        if (sample_q == '0 || sample_q >= bnd[g_q]) begin
          if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + RW'(1);
            state_d = S_WAIT;
          end else begin
            rnd_d   = '0;
            err_d   = 1'b1;
            state_d = S_DELIVER;
          end
        end else begin
          rnd_d   = sample_q;
          err_d   = 1'b0;
          state_d = S_DELIVER;
        end
`else
        rnd_d   = sample_q;
        err_d   = 1'b0;
        state_d = S_DELIVER;
`endif
      end
      S_DELIVER: begin
        if (out_ready[g_q]) begin
          ptr_d   = g_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_SEED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_SEED;
      ptr_q    <= PW'(NREQ - 1);
      g_q      <= '0;
      sample_q <= '0;
      rnd      <= '0;
      err      <= 1'b0;
      seed_q   <= '0;
`ifdef RNG_ARB_REJECT_EN
      retry_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      g_q      <= g_d;
      sample_q <= sample_d;
      rnd      <= rnd_d;
      err      <= err_d;
      if (state_q == S_SEED) begin
        seed_q <= seed;
      end
`ifdef RNG_ARB_REJECT_EN
      retry_q  <= retry_d;
`endif
    end
  end

  // seed is visible on the load cycle itself, then held from the register
  assign gen_seed  = gen_load ? seed : seed_q;
  assign out_valid = (state_q == S_DELIVER) ? (NREQ'(1) << g_q) : '0;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_rng_arbiter.sv
// tb_rng_arbiter: randomized and directed checks of rng_arbiter
// against a request-level reference model.
module tb_rng_arbiter;

  localparam int NREQ      = 2;
  localparam int WIDTH     = 64;
  localparam int MAX_RETRY = 3;
  localparam int LIMIT     = 200;
`ifdef RNG_ARB_REJECT_EN
  localparam bit REJ = 1'b1;
`else
  localparam bit REJ = 1'b0;
`endif
  localparam logic [63:0] SEED0 = 64'h1234_5678_9ABC_DEF0;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [63:0]           seed;
  logic                  gen_load;
  logic [63:0]           gen_seed;
  logic                  gen_req;
  logic                  gen_valid;
  logic [63:0]           gen_data;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] bound;
  logic [NREQ-1:0]       out_valid;
  logic [NREQ-1:0]       out_ready;
  logic [WIDTH-1:0]      rnd;
  logic                  err;
  logic                  busy;

  int checks   = 0;
  int failures = 0;
  int last_g   = NREQ - 1;
  logic [63:0] plan [$];

  rng_arbiter #(
    .NREQ(NREQ),
    .WIDTH(WIDTH),
    .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk),
    .rst(rst),
    .seed(seed),
    .gen_load(gen_load),
    .gen_seed(gen_seed),
    .gen_req(gen_req),
    .gen_valid(gen_valid),
    .gen_data(gen_data),
    .req(req),
    .bound(bound),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .rnd(rnd),
    .err(err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [NREQ-1:0] r, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return 0;
  endfunction

  // outcome of one request: draws consumed, value, error flag
  task automatic predict(input logic [WIDTH-1:0] b, output int n,
                         output logic [WIDTH-1:0] v, output logic e);
    n = 0;
    v = '0;
    e = 1'b1;
    if (REJ && b < 2) return;
    for (int i = 0; i < plan.size(); i++) begin
      logic [WIDTH-1:0] s;
      s = plan[i][WIDTH-1:0];
      n++;
      if (!REJ || (s != 0 && s < b)) begin
        v = s;
        e = 1'b0;
        return;
      end
      if (n == MAX_RETRY + 1) return;
    end
  endtask

  function automatic logic [63:0] rword();
    case ($urandom_range(0, 3))
      0: return 64'd0;
      1: return 64'($urandom_range(1, 8));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  function automatic logic [63:0] rbound();
    case ($urandom_range(0, 3))
      0: return 64'($urandom_range(0, 1));
      1: return 64'($urandom_range(2, 9));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic fill_plan();
    plan.delete();
    for (int i = 0; i <= MAX_RETRY; i++) plan.push_back(rword());
  endtask

  task automatic run_txn(input logic [NREQ-1:0] r, input int hold,
                         input bit drop, input string tag);
    int g, n_exp, n_got, cyc;
    logic [WIDTH-1:0] v_exp;
    logic e_exp;
    logic [NREQ-1:0] oh;
    g = pick(r, last_g);
    predict(bound[g*WIDTH +: WIDTH], n_exp, v_exp, e_exp);
    oh = NREQ'(1) << g;
    req = r;
    n_got = 0;
    cyc = 0;
    while (out_valid == '0 && cyc < LIMIT) begin
      tick();
      if (drop) req = '0;
      if (gen_req) begin
        gen_valid = 1'b1;
        gen_data = (n_got < plan.size()) ? plan[n_got] : 64'd0;
        n_got++;
      end else begin
        gen_valid = 1'($urandom_range(0, 1));
        gen_data = {$urandom, $urandom};
      end
      cyc++;
    end
    check({tag, ".timeout"}, 64'(cyc < LIMIT), 64'd1);
    check({tag, ".valid"}, 64'(out_valid), 64'(oh));
    check({tag, ".rnd"}, 64'(rnd), 64'(v_exp));
    check({tag, ".err"}, 64'(err), 64'(e_exp));
    check({tag, ".draws"}, 64'(n_got), 64'(n_exp));
    out_ready = ~oh & NREQ'($urandom);
    for (int i = 0; i < hold; i++) begin
      tick();
      gen_valid = 1'($urandom_range(0, 1));
      gen_data = {$urandom, $urandom};
      check({tag, ".hold_valid"}, 64'(out_valid), 64'(oh));
      check({tag, ".hold_rnd"}, 64'(rnd), 64'(v_exp));
      check({tag, ".hold_err"}, 64'(err), 64'(e_exp));
    end
    out_ready = out_ready | oh;
    tick();
    out_ready = '0;
    gen_valid = 1'b0;
    check({tag, ".drop_valid"}, 64'(out_valid), 64'd0);
    check({tag, ".idle"}, 64'(busy), 64'd0);
    last_g = g;
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    seed = SEED0;
    gen_valid = 1'b0;
    gen_data = '0;
    req = '0;
    bound = '0;
    out_ready = '0;
    repeat (3) tick();
    check("rst.gen_load", 64'(gen_load), 64'd0);
    check("rst.gen_seed", gen_seed, 64'd0);
    check("rst.gen_req", 64'(gen_req), 64'd0);
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.rnd", 64'(rnd), 64'd0);
    check("rst.err", 64'(err), 64'd0);
    check("rst.busy", 64'(busy), 64'd1);

    rst = 1'b0;
    #1;
    check("seed.load", 64'(gen_load), 64'd1);
    check("seed.value", gen_seed, SEED0);
    tick();
    seed = ~SEED0;
    #1;
    check("seed.load_once", 64'(gen_load), 64'd0);
    check("seed.held", gen_seed, SEED0);
    check("seed.idle", 64'(busy), 64'd0);

    bound[0 +: WIDTH] = 64'd100;
    plan = '{64'd0, 64'd150, 64'd42, 64'd7};
    run_txn(2'b01, 0, 1'b0, "seq");

    bound[0 +: WIDTH] = 64'd5;
    plan = '{64'd9, 64'd9, 64'd9, 64'd9};
    run_txn(2'b01, 1, 1'b0, "exhaust");

    bound[WIDTH +: WIDTH] = 64'd1;
    fill_plan();
    run_txn(2'b10, 0, 1'b0, "small_bound");

    bound[WIDTH +: WIDTH] = 64'd50;
    req = 2'b10;
    cyc = 0;
    while (!gen_req && cyc < 10) begin
      tick();
      cyc++;
    end
    check("mid.reach_wait", 64'(gen_req), 64'd1);
    rst = 1'b1;
    gen_valid = 1'b1;
    gen_data = 64'd5;
    tick();
    check("mid.gen_req", 64'(gen_req), 64'd0);
    check("mid.out_valid", 64'(out_valid), 64'd0);
    check("mid.busy", 64'(busy), 64'd1);
    rst = 1'b0;
    gen_valid = 1'b0;
    #1;
    check("mid.reload", 64'(gen_load), 64'd1);
    tick();
    check("mid.out_valid2", 64'(out_valid), 64'd0);
    last_g = NREQ - 1;

    for (int i = 0; i < 6; i++) begin
      bound[0 +: WIDTH] = rbound();
      bound[WIDTH +: WIDTH] = rbound();
      fill_plan();
      run_txn(2'b11, (i == 2) ? 10 : $urandom_range(0, 2), 1'b0, "rr");
    end

    for (int i = 0; i < 24; i++) begin
      bound[0 +: WIDTH] = rbound();
      bound[WIDTH +: WIDTH] = rbound();
      fill_plan();
      run_txn(NREQ'($urandom_range(1, 3)), $urandom_range(0, 3),
              1'($urandom_range(0, 1)), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
